// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM/direction enums and field/paddle geometry.
// Geometry helpers let each block derive its limits from its own parameters.
package pong_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  localparam int C_FIELD_MAX_DEF = 480;
  localparam int C_PADDLE_H_DEF  = 80;

  function automatic int pmax_of(int field, int paddle);
    return field - paddle;
  endfunction

  function automatic int center_of(int field, int paddle);
    return (field - paddle) / 2;
  endfunction

  localparam int C_PMAX   = pmax_of(C_FIELD_MAX_DEF, C_PADDLE_H_DEF);
  localparam int C_CENTER = center_of(C_FIELD_MAX_DEF, C_PADDLE_H_DEF);

endpackage

// File: rtl/hold_repeat_timer.sv
// Hold/auto-repeat counter: fires after c_DELAY cycles of run,
// then every c_PERIOD cycles until run drops.
module hold_repeat_timer #(
  parameter int c_DELAY  = 8,
  parameter int c_PERIOD = 4
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Start,
  input  logic i_Run,
  output logic o_Fire
);

  localparam int MAXV = (c_DELAY > c_PERIOD) ? c_DELAY : c_PERIOD;
  localparam int TW   = $clog2(MAXV) + 1;

  typedef logic [TW-1:0] cnt_t;

  cnt_t cnt_q, cnt_d;
  logic rep_q, rep_d;

  assign o_Fire = (cnt_q == (rep_q ? cnt_t'(c_PERIOD)
                                   : cnt_t'(c_DELAY)));

  always_comb begin
    cnt_d = '0;
    rep_d = 1'b0;
    if (i_Start) begin
      cnt_d = cnt_t'(1);
    end else if (i_Run) begin
      if (o_Fire) begin
        cnt_d = cnt_t'(1);
        rep_d = 1'b1;
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
        rep_d = rep_q;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: tap-to-step plus hold-to-repeat,
// saturating at the field edges, with serve recentre.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int c_POS_WIDTH     = 10,
  parameter int c_FIELD_MAX     = 480,
  parameter int c_PADDLE_H      = 80,
  parameter int c_HOLD_DELAY    = 6250000,
  parameter int c_REPEAT_PERIOD = 250000,
  parameter int c_STEP          = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_Up,
  input  logic                   i_Dn,
  input  logic                   i_Enable,
  input  logic                   i_Center,
  output logic [c_POS_WIDTH-1:0] o_Pos,
  output logic                   o_Step,
  output logic                   o_Busy
);

  localparam int PMAX   = pmax_of(c_FIELD_MAX, c_PADDLE_H);
  localparam int CENTER = center_of(c_FIELD_MAX, c_PADDLE_H);

  typedef logic [c_POS_WIDTH-1:0] pos_t;
  typedef logic [c_POS_WIDTH:0]   ext_t;

  dir_e   dir, prev_q;
  state_e state_q, state_d;
  pos_t   pos_q, pos_d;
  logic   step_q, step_d;
  logic   busy_q, busy_d;
  logic   press, do_step;
  logic   t_start, t_run, t_fire;
  ext_t   cur, up_v, dn_v, sum;

  always_comb begin
    dir = DIR_NONE;
    unique case (1'b1)
      (i_Up & ~i_Dn): dir = DIR_UP;
      (i_Dn & ~i_Up): dir = DIR_DN;
      default:        dir = DIR_NONE;
    endcase
  end

  assign press = (dir != DIR_NONE) && (dir != prev_q);

  // Extra bit keeps the saturating add/sub from wrapping.
  always_comb begin
    cur  = {1'b0, pos_q};
    sum  = cur + ext_t'(c_STEP);
    up_v = (cur >= ext_t'(c_STEP)) ? cur - ext_t'(c_STEP) : '0;
    dn_v = (sum > ext_t'(PMAX)) ? ext_t'(PMAX) : sum;
  end

  always_comb begin
    state_d = state_q;
    do_step = 1'b0;
    t_start = 1'b0;
    t_run   = 1'b0;
    if (!i_Enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (press) begin
            do_step = 1'b1;
            t_start = 1'b1;
            state_d = S_DELAY;
          end
        end
        S_DELAY, S_REPEAT: begin
          if (dir == DIR_NONE) begin
            state_d = S_IDLE;
          end else if (press) begin
            do_step = 1'b1;
            t_start = 1'b1;
            state_d = S_DELAY;
          end else begin
            t_run = 1'b1;
            if (t_fire) begin
              do_step = 1'b1;
              state_d = S_REPEAT;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    pos_d = pos_q;
    if (do_step) begin
      pos_d = (dir == DIR_UP) ? pos_t'(up_v) : pos_t'(dn_v);
    end

    if (i_Center) begin
      state_d = S_IDLE;
      t_start = 1'b0;
      t_run   = 1'b0;
      pos_d   = pos_t'(CENTER);
    end

    step_d = (pos_d != pos_q) && !i_Center;
    busy_d = (state_d != S_IDLE);
  end

  hold_repeat_timer #(
    .c_DELAY (c_HOLD_DELAY),
    .c_PERIOD(c_REPEAT_PERIOD)
  ) u_timer (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .i_Start(t_start),
    .i_Run  (t_run),
    .o_Fire (t_fire)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      prev_q  <= DIR_NONE;
      pos_q   <= pos_t'(CENTER);
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= dir;
      pos_q   <= pos_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
    end
  end

  assign o_Pos  = pos_q;
  assign o_Step = step_q;
  assign o_Busy = busy_q;

endmodule
